// File: rtl/draw_pkg.sv
// Shared types for the draw scheduler: screen limits, pixel fields and FSM states.
package draw_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  typedef logic [7:0] x_t;
  typedef logic [6:0] y_t;
  typedef logic [2:0] colour_t;

  typedef struct packed {
    x_t      x;
    y_t      y;
    colour_t colour;
    logic    plot;
  } pix_t;

  localparam x_t X_LIM = x_t'(SCREEN_W);
  localparam y_t Y_LIM = y_t'(SCREEN_H);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FILL     = 3'd1,
    S_FILL_REL = 3'd2,
    S_CIRC     = 3'd3,
    S_CIRC_REL = 3'd4,
    S_DONE     = 3'd5
  } state_t;

endpackage

// File: rtl/plot_mux.sv
// Zero-latency pixel port select between fill and circle engines.
// Optional off-screen plot suppression when DRAW_SCHEDULER_CLIP_EN is defined.
module plot_mux
  import draw_pkg::*;
(
  input  logic i_sel_fill,
  input  logic i_sel_circ,
  input  pix_t i_fill,
  input  pix_t i_circ,
  output pix_t o_pix
);

  pix_t w_sel;

  always_comb begin
    w_sel = '0;
    if (i_sel_fill)      w_sel = i_fill;
    else if (i_sel_circ) w_sel = i_circ;
  end

`ifdef DRAW_SCHEDULER_CLIP_EN
  always_comb begin
    o_pix      = w_sel;
    // coordinates still pass through so the adapter sees what the engine drove
    o_pix.plot = w_sel.plot && (w_sel.x < X_LIM) && (w_sel.y < Y_LIM);
  end
`else
  assign o_pix = w_sel;
`endif

endmodule

// File: rtl/draw_scheduler.sv
// Sequences an optional screen fill then a circle draw, sharing one VGA pixel port.
// Build option: DRAW_SCHEDULER_CLIP_EN suppresses plots outside the screen.
module draw_scheduler
  import draw_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       clear_en,
  output logic       done,
  output logic       fill_start,
  input  logic       fill_done,
  input  logic [7:0] fill_x,
  input  logic [6:0] fill_y,
  input  logic [2:0] fill_colour,
  input  logic       fill_plot,
  output logic       circ_start,
  input  logic       circ_done,
  input  logic [7:0] circ_x,
  input  logic [6:0] circ_y,
  input  logic [2:0] circ_colour,
  input  logic       circ_plot,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot
);

  state_t r_state, w_next;
  logic   r_clear_en;
  pix_t   w_fill, w_circ, w_vga;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (start)      w_next = clear_en ? S_FILL : S_CIRC;
      S_FILL:     if (fill_done)  w_next = S_FILL_REL;
      S_FILL_REL: if (!fill_done) w_next = S_CIRC;
      S_CIRC:     if (circ_done)  w_next = S_CIRC_REL;
      S_CIRC_REL: if (!circ_done) w_next = S_DONE;
      S_DONE:     if (!start)     w_next = S_IDLE;
      default:                    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_clear_en <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && start) r_clear_en <= clear_en;
    end
  end

  // fill only runs in a sequence that asked for it
  assign fill_start = (r_state == S_FILL) && r_clear_en;
  assign circ_start = (r_state == S_CIRC);
  assign done       = (r_state == S_DONE);

  assign w_fill = '{x: fill_x, y: fill_y, colour: fill_colour, plot: fill_plot};
  assign w_circ = '{x: circ_x, y: circ_y, colour: circ_colour, plot: circ_plot};

  plot_mux u_plot_mux (
    .i_sel_fill (fill_start),
    .i_sel_circ (circ_start),
    .i_fill     (w_fill),
    .i_circ     (w_circ),
    .o_pix      (w_vga)
  );

  assign vga_x      = w_vga.x;
  assign vga_y      = w_vga.y;
  assign vga_colour = w_vga.colour;
  assign vga_plot   = w_vga.plot;

endmodule

// File: tb/tb_draw_scheduler.sv
// Directed and randomized check of draw_scheduler against a phase-list model.
module tb_draw_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, clear_en = 1'b0;
  logic       done, fill_start, circ_start;
  logic       fill_done = 1'b0, circ_done = 1'b0;
  logic [7:0] fill_x = '0, circ_x = '0;
  logic [6:0] fill_y = '0, circ_y = '0;
  logic [2:0] fill_colour = '0, circ_colour = '0;
  logic       fill_plot = 1'b0, circ_plot = 1'b0;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;

  int n_pass = 0;
  int n_tot  = 0;

  draw_scheduler dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear_en(clear_en), .done(done),
    .fill_start(fill_start), .fill_done(fill_done), .fill_x(fill_x), .fill_y(fill_y),
    .fill_colour(fill_colour), .fill_plot(fill_plot),
    .circ_start(circ_start), .circ_done(circ_done), .circ_x(circ_x), .circ_y(circ_y),
    .circ_colour(circ_colour), .circ_plot(circ_plot),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Model: the remaining phases of the current sequence, head is the active one.
  // 'F' fill running, 'f' waiting fill_done low, 'C' circle running,
  // 'c' waiting circ_done low, 'D' done shown. Empty list = idle.
  byte phases[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) phases.delete();
    else if (phases.size() == 0) begin
      if (start) begin
        if (clear_en) phases = '{"F", "f", "C", "c", "D"};
        else          phases = '{"C", "c", "D"};
      end
    end else begin
      case (phases[0])
        "F": if (fill_done)  void'(phases.pop_front());
        "f": if (!fill_done) void'(phases.pop_front());
        "C": if (circ_done)  void'(phases.pop_front());
        "c": if (!circ_done) void'(phases.pop_front());
        "D": if (!start)     void'(phases.pop_front());
        default: ;
      endcase
    end
  end

  function automatic byte head();
    return (phases.size() == 0) ? "I" : phases[0];
  endfunction

  function automatic bit on_screen(input int x, input int y);
`ifdef DRAW_SCHEDULER_CLIP_EN
    return (x < 160) && (y < 120);
`else
    return 1'b1;
`endif
  endfunction

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    int ex, ey, ec, ep;
    byte h;
    h = head();
    ex = 0; ey = 0; ec = 0; ep = 0;
    if (h == "F") begin
      ex = fill_x; ey = fill_y; ec = fill_colour;
      ep = fill_plot && on_screen(fill_x, fill_y);
    end else if (h == "C") begin
      ex = circ_x; ey = circ_y; ec = circ_colour;
      ep = circ_plot && on_screen(circ_x, circ_y);
    end
    chk("m_fill_start", fill_start, h == "F");
    chk("m_circ_start", circ_start, h == "C");
    chk("m_done", done, h == "D");
    chk("m_vga_x", vga_x, ex);
    chk("m_vga_y", vga_y, ey);
    chk("m_vga_colour", vga_colour, ec);
    chk("m_vga_plot", vga_plot, ep);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit clip;
`ifdef DRAW_SCHEDULER_CLIP_EN
    clip = 1'b1;
`else
    clip = 1'b0;
`endif
    repeat (3) step();
    rst_n = 1'b1;
    #1;
    chk("rst_done", done, 0);
    chk("rst_fill_start", fill_start, 0);
    chk("rst_circ_start", circ_start, 0);
    chk("rst_vga_plot", vga_plot, 0);
    step();

    // fill then circle
    start = 1; clear_en = 1;
    fill_x = 5; fill_y = 7; fill_colour = 4; fill_plot = 1;
    #1 chk("idle_vga_plot", vga_plot, 0);
    step();
    clear_en = 0;
    #1;
    chk("fill_start_on", fill_start, 1);
    chk("fill_circ_off", circ_start, 0);
    chk("fill_vga_x", vga_x, 5);
    chk("fill_vga_y", vga_y, 7);
    chk("fill_vga_col", vga_colour, 4);
    chk("fill_vga_plot", vga_plot, 1);
    fill_done = 1;
    step();
    fill_done = 0;
    #1;
    chk("fillrel_fill_start", fill_start, 0);
    chk("fillrel_circ_start", circ_start, 0);
    chk("fillrel_vga_plot", vga_plot, 0);
    step();
    circ_x = 20; circ_y = 30; circ_colour = 2; circ_plot = 1;
    fill_x = 99; fill_plot = 1;
    #1;
    chk("circ_start_on", circ_start, 1);
    chk("circ_vga_x", vga_x, 20);
    chk("circ_vga_y", vga_y, 30);
    chk("circ_vga_col", vga_colour, 2);
    chk("circ_vga_plot", vga_plot, 1);
    circ_done = 1;
    step();
    circ_done = 0;
    step();
    #1 chk("done_on", done, 1);
    start = 0;
    step();
    #1 chk("done_off", done, 0);

    // circle only, clip boundary
    start = 1; clear_en = 0;
    step();
    #1;
    chk("c_only_circ_start", circ_start, 1);
    chk("c_only_fill_start", fill_start, 0);
    circ_x = 160; circ_y = 10; circ_plot = 1;
    #1 chk("clip_x160_plot", vga_plot, clip ? 0 : 1);
    circ_x = 159;
    #1 chk("clip_x159_plot", vga_plot, 1);
    circ_y = 120;
    #1 chk("clip_y120_plot", vga_plot, clip ? 0 : 1);
    circ_y = 119;
    step();

    // asynchronous reset mid-circle
    rst_n = 0;
    #1;
    chk("arst_circ_start", circ_start, 0);
    chk("arst_vga_plot", vga_plot, 0);
    chk("arst_vga_x", vga_x, 0);
    chk("arst_done", done, 0);
    start = 0; circ_plot = 0;
    step();
    rst_n = 1;
    step();
    #1 chk("post_rst_idle", circ_start | fill_start, 0);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      start       = ($urandom_range(0, 9) < 7);
      clear_en    = $urandom_range(0, 1);
      fill_done   = ($urandom_range(0, 9) < 3);
      circ_done   = ($urandom_range(0, 9) < 3);
      fill_x      = 8'($urandom_range(0, 255));
      fill_y      = 7'($urandom_range(0, 127));
      fill_colour = 3'($urandom_range(0, 7));
      fill_plot   = $urandom_range(0, 1);
      circ_x      = 8'($urandom_range(0, 255));
      circ_y      = 7'($urandom_range(0, 127));
      circ_colour = 3'($urandom_range(0, 7));
      circ_plot   = $urandom_range(0, 1);
      if ($urandom_range(0, 199) == 0) begin
        #1 rst_n = 0;
        #1 rst_n = 1;
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/draw_scheduler.md
DRAW_SCHEDULER -- requirements
Module: draw_scheduler

Interface
REQ-001 SCREEN_W, 160, horizontal pixel count; legal x is 0..SCREEN_W-1.
REQ-002 SCREEN_H, 120, vertical pixel count; legal y is 0..SCREEN_H-1.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  level request; held high until done is seen.
REQ-006 clear_en  input  1  sampled with start; 1 = run fill engine before circle engine.
REQ-007 done  output  1  sequence complete; held until start is low.
REQ-008 fill_start  output  1  level start to fill engine.
REQ-009 fill_done  input  1  fill engine completion.
REQ-010 fill_x, fill_y, fill_colour, fill_plot  input  8/7/3/1  fill engine pixel port.
REQ-011 circ_start  output  1  level start to circle engine.
REQ-012 circ_done  input  1  circle engine completion.
REQ-013 circ_x, circ_y, circ_colour, circ_plot  input  8/7/3/1  circle engine pixel port.
REQ-014 vga_x, vga_y, vga_colour, vga_plot  output  8/7/3/1  shared pixel port to VGA adapter.

Function
REQ-015 States: IDLE, FILL, FILL_REL, CIRC, CIRC_REL, DONE.
REQ-016 IDLE: on start=1, go to FILL if clear_en=1, otherwise to CIRC; clear_en latched on this edge only.
REQ-017 FILL: fill_start=1; on fill_done=1, go to FILL_REL.
REQ-018 FILL_REL: fill_start=0; when fill_done=0, go to CIRC.
REQ-019 CIRC: circ_start=1; on circ_done=1, go to CIRC_REL.
REQ-020 CIRC_REL: circ_start=0; when circ_done=0, go to DONE.
REQ-021 DONE: done=1; go to IDLE on the first edge with start=0, so done is high for exactly 1 cycle if start is already low.
REQ-022 fill_start and circ_start are never high together; each is a registered state decode.
REQ-023 Pixel mux is combinational with zero latency: FILL selects the fill port and CIRC selects the circle port.
REQ-024 In all other states, vga_plot=0 and vga_x/vga_y/vga_colour=0.
REQ-025 Engine plot inputs are ignored outside the engine's own active state.
REQ-026 start dropping mid-sequence is ignored; the sequence runs to DONE.
REQ-027 An engine done already high on entry to FILL or CIRC is accepted, with advance on the next edge.

Reset
REQ-028 rst_n=0 forces IDLE immediately, with done=0, fill_start=0, circ_start=0, vga_plot=0, vga_x/vga_y/vga_colour=0, and latched clear_en=0, including mid-operation.
REQ-029 After reset release, no engine start is asserted until start=1 is sampled in IDLE.

Configuration
REQ-030 Macro DRAW_SCHEDULER_CLIP_EN defined: vga_plot is forced to 0 for any selected pixel with x>=SCREEN_W or y>=SCREEN_H; x, y and colour still pass through.
REQ-031 Macro undefined: the selected plot passes through unmodified, with no comparators instantiated.

Structure
REQ-032 Shared package draw_pkg holds SCREEN_W/SCREEN_H defaults, coordinate typedefs (8-bit x, 7-bit y, 3-bit colour) and the scheduler state enum.
REQ-033 One sub-module, plot_mux, implements the pixel port selection and the optional clipping.
REQ-034 The FSM resides in draw_scheduler.

Verification
REQ-035 Reset, then start=1 with clear_en=1 -> fill_start=1 on the next cycle; circ_start=0; vga mirrors the fill port (fill_x=5, fill_y=7, colour=4, plot=1 -> same on vga).
REQ-036 Pulse fill_done 1 cycle -> fill_start=0 in FILL_REL, then circ_start=1 one cycle later; circ_done pulse -> done=1; start=0 -> done=0 the next cycle.
REQ-037 start=1 with clear_en=0 -> fill_start stays 0 throughout; circ_start=1 on the next cycle.
REQ-038 rst_n=0 during CIRC with circ_plot=1 -> circ_start=0 and vga_plot=0 with no clock edge; state=IDLE.
REQ-039 DRAW_SCHEDULER_CLIP_EN defined, circ_x=160, circ_y=10, circ_plot=1 -> vga_plot=0; circ_x=159 -> vga_plot=1.
REQ-040 fill_plot=1 while in CIRC -> ignored; vga shows circle port values only.
